// File: rtl/booth_wallace_pipe.sv
// Weights eight raw radix-4 Booth partial products, reduces them in a 3-stage carry-save tree plus CPA.
// Latency 3 cycles at one op/cycle; bubble-collapsing valid/ready so a stalled output only backs up full stages.
module booth_wallace_pipe #(
   parameter int W     = 32,
   parameter int N_PP  = 8,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W*N_PP-1:0]   pp_in,
   input  logic [TAG_W-1:0]    tag_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        prod_out,
   output logic [TAG_W-1:0]    tag_out
);

   function automatic logic [W-1:0] csa_s(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
      return a ^ b ^ c;
   endfunction

   // Carry moves up one bit; the carry out of the MSB is dropped (mod 2^W).
   function automatic logic [W-1:0] csa_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
      return ((a & b) | (a & c) | (b & c)) << 1;
   endfunction

   logic [W-1:0]     w_t [N_PP];

   logic             w_en1, w_en2, w_en3;
   logic             r_v1, r_v2, r_v3;

   logic [W-1:0]     w_l1_s0, w_l1_c0, w_l1_s1, w_l1_c1;
   logic [W-1:0]     w_l2_s0, w_l2_c0, w_l2_s1, w_l2_c1;
   logic [W-1:0]     r_s1_a, r_s1_b, r_s1_c, r_s1_d;
   logic [TAG_W-1:0] r_s1_tag;

   logic [W-1:0]     w_l3_s, w_l3_c, w_l4_s, w_l4_c;
   logic [W-1:0]     r_s2_sum, r_s2_car;
   logic [TAG_W-1:0] r_s2_tag;

   logic [W-1:0]     r_prod;
   logic [TAG_W-1:0] r_s3_tag;

   for (genvar gi = 0; gi < N_PP; gi++) begin : g_weight
      assign w_t[gi] = pp_in[W*gi +: W] << (2*gi);
   end

   // A stage may load whenever it is empty or the stage after it is moving.
   assign w_en3    = !r_v3 || out_ready;
   assign w_en2    = !r_v2 || w_en3;
   assign w_en1    = !r_v1 || w_en2;
   assign in_ready = w_en1;

   assign w_l1_s0 = csa_s(w_t[0], w_t[1], w_t[2]);
   assign w_l1_c0 = csa_c(w_t[0], w_t[1], w_t[2]);
   assign w_l1_s1 = csa_s(w_t[3], w_t[4], w_t[5]);
   assign w_l1_c1 = csa_c(w_t[3], w_t[4], w_t[5]);

   assign w_l2_s0 = csa_s(w_l1_s0, w_l1_c0, w_l1_s1);
   assign w_l2_c0 = csa_c(w_l1_s0, w_l1_c0, w_l1_s1);
   assign w_l2_s1 = csa_s(w_l1_c1, w_t[6], w_t[7]);
   assign w_l2_c1 = csa_c(w_l1_c1, w_t[6], w_t[7]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_c   <= '0;
         r_s1_d   <= '0;
         r_s1_tag <= '0;
      end else if (w_en1) begin
         r_v1     <= in_valid;
         r_s1_a   <= w_l2_s0;
         r_s1_b   <= w_l2_c0;
         r_s1_c   <= w_l2_s1;
         r_s1_d   <= w_l2_c1;
         r_s1_tag <= tag_in;
      end
   end

   assign w_l3_s = csa_s(r_s1_a, r_s1_b, r_s1_c);
   assign w_l3_c = csa_c(r_s1_a, r_s1_b, r_s1_c);
   assign w_l4_s = csa_s(w_l3_s, w_l3_c, r_s1_d);
   assign w_l4_c = csa_c(w_l3_s, w_l3_c, r_s1_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2     <= 1'b0;
         r_s2_sum <= '0;
         r_s2_car <= '0;
         r_s2_tag <= '0;
      end else if (w_en2) begin
         r_v2     <= r_v1;
         r_s2_sum <= w_l4_s;
         r_s2_car <= w_l4_c;
         r_s2_tag <= r_s1_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3     <= 1'b0;
         r_prod   <= '0;
         r_s3_tag <= '0;
      end else if (w_en3) begin
         r_v3     <= r_v2;
         r_prod   <= r_s2_sum + r_s2_car;
         r_s3_tag <= r_s2_tag;
      end
   end

   assign out_valid = r_v3;
   assign prod_out  = r_prod;
   assign tag_out   = r_s3_tag;

endmodule

// File: tb/tb_booth_wallace_pipe.sv
// Directed and randomised checks of the Booth/Wallace product pipeline against a signed-multiply model.
module tb_booth_wallace_pipe;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] pp_in;
   logic [3:0]   tag_in;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  prod_out;
   logic [3:0]   tag_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [35:0]  exp_q[$];
   logic         s_rdy, s_vld, s_ifire, s_ofire;
   logic [31:0]  s_prod;
   logic [3:0]   s_tag;

   always #5 clk = ~clk;

   booth_wallace_pipe #(.W(32), .N_PP(8), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp_in     (pp_in),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod_out  (prod_out),
      .tag_out   (tag_out)
   );

   // Radix-4 Booth digits of b, each applied to sign-extended a, left unshifted.
   function automatic logic [255:0] booth(input logic [15:0] a, input logic [15:0] b);
      logic [255:0]       r;
      logic [16:0]        bx;
      logic signed [31:0] ax, pp;
      logic [2:0]         tr;
      bx = {b, 1'b0};
      ax = {{16{a[15]}}, a};
      r  = '0;
      for (int i = 0; i < 8; i++) begin
         tr = bx[2*i +: 3];
         case (tr)
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax <<< 1;
            3'b100:         pp = -(ax <<< 1);
            3'b101, 3'b110: pp = -ax;
            default:        pp = '0;
         endcase
         r[32*i +: 32] = pp;
      end
      return r;
   endfunction

   function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
   endfunction

   // One cycle: drive inputs, sample pre-edge handshake state, advance past the edge.
   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tg, input logic ordy);
      logic [31:0] p;
      in_valid  = v;
      tag_in    = v ? tg : 4'($urandom());
      pp_in     = v ? booth(a, b) : {8{32'($urandom())}};
      out_ready = ordy;
      #1;
      s_rdy   = in_ready;
      s_vld   = out_valid;
      s_prod  = prod_out;
      s_tag   = tag_out;
      s_ifire = v & in_ready;
      s_ofire = out_valid & ordy;
      if (s_ifire) begin
         p = mul(a, b);
         exp_q.push_back({p, tg});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pp_in     = '1;
      tag_in    = 4'hF;
      #12;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++;
      if (prod_out !== 32'h0) begin n_errors++; $display("FAIL reset_prod got=%h exp=0", prod_out); end
      n_checks++;
      if (tag_out !== 4'h0) begin n_errors++; $display("FAIL reset_tag got=%h exp=0", tag_out); end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [15:0] va [7] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 16'hFFFD, 16'h0100};
      logic [15:0] vb [7] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0005, 16'h0100};
      logic [3:0]  vt [7] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hC};
      logic [31:0] vp [7] = '{32'h3FFF0001, 32'h40000000, 32'hC0008000, 32'h00000000,
                              32'h00000001, 32'hFFFFFFF1, 32'h00010000};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, va[i], vb[i], vt[i], 1'b1);
         n_checks++;
         if (s_ifire !== 1'b1) begin n_errors++; $display("FAIL dir_accept[%0d] got=%b exp=1", i, s_ifire); end
         n_checks++;
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL dir_lat1[%0d] got=%b exp=0", i, out_valid); end
         drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         n_checks++;
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL dir_lat2[%0d] got=%b exp=0", i, out_valid); end
         drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         n_checks++;
         if (out_valid !== 1'b1) begin n_errors++; $display("FAIL dir_lat3[%0d] got=%b exp=1", i, out_valid); end
         n_checks++;
         if (prod_out !== vp[i]) begin n_errors++; $display("FAIL dir_prod[%0d] got=%h exp=%h", i, prod_out, vp[i]); end
         n_checks++;
         if (tag_out !== vt[i]) begin n_errors++; $display("FAIL dir_tag[%0d] got=%h exp=%h", i, tag_out, vt[i]); end
         drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int          got = 0;
      logic [35:0] e;
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (cyc < 16) drive(1'b1, 16'($urandom()), 16'($urandom()), 4'(cyc), 1'b1);
         else          drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         if (cyc < 16) begin
            n_checks++;
            if (s_ifire !== 1'b1) begin n_errors++; $display("FAIL b2b_accept[%0d] got=%b exp=1", cyc, s_ifire); end
         end
         n_checks++;
         if (s_ofire !== (cyc >= 3 && cyc < 19)) begin
            n_errors++;
            $display("FAIL b2b_out_vld[%0d] got=%b exp=%b", cyc, s_ofire, (cyc >= 3 && cyc < 19));
         end
         if (s_ofire && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got++;
            n_checks++;
            if ({s_prod, s_tag} !== e) begin
               n_errors++;
               $display("FAIL b2b_data[%0d] got=%h/%h exp=%h/%h", cyc, s_prod, s_tag, e[35:4], e[3:0]);
            end
         end
      end
      n_checks++;
      if (got !== 16) begin n_errors++; $display("FAIL b2b_count got=%0d exp=16", got); end
   endtask

   task automatic test_fill_drain();
      logic [35:0] e;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'(16'h0101 * (i + 2)), 16'(16'hFF00 + i), 4'(i + 1), 1'b0);
         n_checks++;
         if (s_ifire !== (i < 3)) begin n_errors++; $display("FAIL fill_accept[%0d] got=%b exp=%b", i, s_ifire, (i < 3)); end
         if (i >= 3) begin
            n_checks++;
            if (s_prod !== exp_q[0][35:4] || s_tag !== exp_q[0][3:0]) begin
               n_errors++;
               $display("FAIL fill_hold[%0d] got=%h/%h exp=%h/%h", i, s_prod, s_tag, exp_q[0][35:4], exp_q[0][3:0]);
            end
         end
      end
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         if (j == 0) begin
            n_checks++;
            if (s_rdy !== 1'b1) begin n_errors++; $display("FAIL drain_in_ready got=%b exp=1", s_rdy); end
         end
         n_checks++;
         if (s_ofire !== 1'b1 || exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL drain_vld[%0d] got=%b exp=1", j, s_ofire);
         end else begin
            e = exp_q.pop_front();
            n_checks++;
            if ({s_prod, s_tag} !== e) begin
               n_errors++;
               $display("FAIL drain_data[%0d] got=%h/%h exp=%h/%h", j, s_prod, s_tag, e[35:4], e[3:0]);
            end
         end
      end
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_random();
      int          sent = 0;
      int          recv = 0;
      logic        prev_stall = 1'b0;
      logic [31:0] prev_prod = '0;
      logic [3:0]  prev_tag = '0;
      logic        v, ordy;
      logic [35:0] e;
      for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
         v    = (sent < 1000) && ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         drive(v, 16'($urandom()), 16'($urandom()), 4'($urandom()), ordy);
         if (prev_stall) begin
            n_checks++;
            if (s_vld !== 1'b1 || s_prod !== prev_prod || s_tag !== prev_tag) begin
               n_errors++;
               $display("FAIL rnd_hold[%0d] got=%b/%h/%h exp=1/%h/%h", cyc, s_vld, s_prod, s_tag, prev_prod, prev_tag);
            end
         end
         prev_stall = s_vld & !ordy;
         prev_prod  = s_prod;
         prev_tag   = s_tag;
         if (s_ifire) sent++;
         if (s_ofire) begin
            recv++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL rnd_extra[%0d] got=%h/%h exp=none", cyc, s_prod, s_tag);
            end else begin
               e = exp_q.pop_front();
               if ({s_prod, s_tag} !== e) begin
                  n_errors++;
                  $display("FAIL rnd_data[%0d] got=%h/%h exp=%h/%h", cyc, s_prod, s_tag, e[35:4], e[3:0]);
               end
            end
         end
      end
      n_checks++;
      if (recv !== 1000 || exp_q.size() !== 0) begin
         n_errors++;
         $display("FAIL rnd_count got=%0d left=%0d exp=1000 left=0", recv, exp_q.size());
      end
   endtask

   task automatic test_midreset();
      drive(1'b1, 16'h0123, 16'h0045, 4'h1, 1'b0);
      drive(1'b1, 16'h0321, 16'h0054, 4'h2, 1'b0);
      drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mrst_pre_vld got=%b exp=1", out_valid); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_vld got=%b exp=0", out_valid); end
      n_checks++;
      if (prod_out !== 32'h0 || tag_out !== 4'h0) begin
         n_errors++;
         $display("FAIL mrst_data got=%h/%h exp=0/0", prod_out, tag_out);
      end
      exp_q.delete();
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
         n_checks++;
         if (s_vld !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mrst_stale[%0d] got=%b exp=0", i, out_valid);
         end
      end
      drive(1'b1, 16'h0012, 16'hFFFE, 4'hB, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_lat1 got=%b exp=0", out_valid); end
      drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_lat2 got=%b exp=0", out_valid); end
      drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || prod_out !== 32'hFFFFFFDC || tag_out !== 4'hB) begin
         n_errors++;
         $display("FAIL mrst_next got=%b/%h/%h exp=1/ffffffdc/b", out_valid, prod_out, tag_out);
      end
      drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b1);
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_fill_drain();
      test_random();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
